// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states, flag bit positions.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_DBZ   = 3;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath: shift-add multiply, plus restoring divide when MULTICYCLE_ALU_DIV_EN
// is defined. One step per cycle for WIDTH cycles after start.
module alu_iter_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef MULTICYCLE_ALU_DIV_EN
    input  logic             div_mode,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic             carry,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             running_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q, q_q, b_q;
    logic [WIDTH-1:0] acc_n, q_n, addend;
    logic [WIDTH:0]   mul_sum;
`ifdef MULTICYCLE_ALU_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   div_shift;
`endif

    // {acc, q} is the double-width working register: product for mul, {remainder, quotient} for div
    always_comb begin
        addend  = q_q[0] ? b_q : '0;
        mul_sum = {1'b0, acc_q} + {1'b0, addend};
        acc_n   = mul_sum[WIDTH:1];
        q_n     = {mul_sum[0], q_q[WIDTH-1:1]};
        carry   = (acc_n != '0);
`ifdef MULTICYCLE_ALU_DIV_EN
        div_shift = {acc_q, q_q[WIDTH-1]};
        if (div_q) begin
            carry = 1'b0;
            if (div_shift >= {1'b0, b_q}) begin
                acc_n = div_shift[WIDTH-1:0] - b_q;
                q_n   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = div_shift[WIDTH-1:0];
                q_n   = {q_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    assign last   = running_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign res_lo = q_n;
    assign res_hi = acc_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            b_q       <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
            div_q     <= 1'b0;
`endif
        end else if (start) begin
            running_q <= 1'b1;
            cnt_q     <= '0;
            acc_q     <= '0;
            q_q       <= a;
            b_q       <= b;
`ifdef MULTICYCLE_ALU_DIV_EN
            div_q     <= div_mode;
`endif
        end else if (running_q) begin
            acc_q <= acc_n;
            q_q   <= q_n;
            cnt_q <= cnt_q + 1'b1;
            if (last) running_q <= 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU with valid/ready handshake: one-cycle add/sub, WIDTH-cycle mul.
// Divide is present only when MULTICYCLE_ALU_DIV_EN is defined; otherwise op 0100 acts as add.
module multicycle_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags
);
    import alu_pkg::*;

    state_t           state_q, state_n;
    logic             accept, iter_op, is_sub, is_mul;
    logic [WIDTH:0]   add_sum, sub_diff;
    logic [WIDTH-1:0] imm_lo, imm_hi;
    logic [3:0]       imm_flags, iter_flags;
    logic             core_last, core_carry;
    logic [WIDTH-1:0] core_lo, core_hi;
    logic [WIDTH-1:0] result_q, result_hi_q;
    logic [3:0]       flags_q;
`ifdef MULTICYCLE_ALU_DIV_EN
    logic             is_div, div_zero;
`endif

    // Two's-complement overflow of x + y given the sign bits of x, y and the sum
    function automatic logic signed_ovf(input logic sx, input logic sy, input logic sr);
        return (sx == sy) && (sr != sx);
    endfunction

    always_comb begin
        is_sub    = (op == OP_SUB);
        is_mul    = (op == OP_MUL);
        add_sum   = {1'b0, a} + {1'b0, b};
        sub_diff  = {1'b0, a} - {1'b0, b};
        imm_hi    = '0;
        imm_flags = '0;
        iter_op   = is_mul;
        if (is_sub) begin
            imm_lo                = sub_diff[WIDTH-1:0];
            imm_flags[FLAG_CARRY] = sub_diff[WIDTH];
            imm_flags[FLAG_OVF]   = signed_ovf(a[WIDTH-1], ~b[WIDTH-1], sub_diff[WIDTH-1]);
        end else begin
            imm_lo                = add_sum[WIDTH-1:0];
            imm_flags[FLAG_CARRY] = add_sum[WIDTH];
            imm_flags[FLAG_OVF]   = signed_ovf(a[WIDTH-1], b[WIDTH-1], add_sum[WIDTH-1]);
        end
`ifdef MULTICYCLE_ALU_DIV_EN
        is_div   = (op == OP_DIV);
        div_zero = is_div && (b == '0);
        iter_op  = is_mul || (is_div && !div_zero);
        if (div_zero) begin
            imm_lo              = '1;
            imm_hi              = a;
            imm_flags           = '0;
            imm_flags[FLAG_DBZ] = 1'b1;
        end
`endif
        imm_flags[FLAG_ZERO]   = (imm_lo == '0);
        iter_flags             = '0;
        iter_flags[FLAG_ZERO]  = (core_lo == '0);
        iter_flags[FLAG_CARRY] = core_carry;
    end

    always_comb begin
        state_n = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: if (in_valid) begin
                accept  = 1'b1;
                state_n = iter_op ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: if (core_last) state_n = ST_DONE;
            ST_DONE: if (out_ready) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_n;
    end

    // Result registers only change on a single-cycle accept or the final iteration step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else if (accept && !iter_op) begin
            result_q    <= imm_lo;
            result_hi_q <= imm_hi;
            flags_q     <= imm_flags;
        end else if (core_last) begin
            result_q    <= core_lo;
            result_hi_q <= core_hi;
            flags_q     <= iter_flags;
        end
    end

    alu_iter_core #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept && iter_op),
`ifdef MULTICYCLE_ALU_DIV_EN
        .div_mode (is_div),
`endif
        .a        (a),
        .b        (b),
        .last     (core_last),
        .carry    (core_carry),
        .res_lo   (core_lo),
        .res_hi   (core_hi)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH = 8), randomized against an arithmetic reference model.
module tb_multicycle_alu;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [3:0]       op = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result, result_hi;
    logic [3:0]       flags;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags)
    );

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [3:0] fl;
        int         lat;
    } exp_t;

    // Reference: plain integer arithmetic; lat = cycles from accept edge to out_valid visible
    function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int ux, uy, sx, sy, r;
        logic dbz, ovf, cy;
        ux = x; uy = y;
        sx = $signed(x); sy = $signed(y);
        dbz = 1'b0; ovf = 1'b0; cy = 1'b0;
        e.hi = 8'h00; e.lat = 1;
        if (o == 4'b0011) begin
            r = ux * uy;
            e.lo = 8'(r % 256); e.hi = 8'(r / 256); cy = (r >= 256); e.lat = 9;
        end
`ifdef MULTICYCLE_ALU_DIV_EN
        else if (o == 4'b0100 && uy == 0) begin
            e.lo = 8'hFF; e.hi = x; dbz = 1'b1;
        end else if (o == 4'b0100) begin
            e.lo = 8'(ux / uy); e.hi = 8'(ux % uy); e.lat = 9;
        end
`endif
        else if (o == 4'b0010) begin
            e.lo = 8'(ux - uy); cy = (ux < uy);
            r = sx - sy; ovf = (r > 127) || (r < -128);
        end else begin
            e.lo = 8'(ux + uy); cy = ((ux + uy) > 255);
            r = sx + sy; ovf = (r > 127) || (r < -128);
        end
        e.fl = {dbz, ovf, cy, (e.lo == 8'h00)};
        return e;
    endfunction

    // Drives one request and waits for out_valid; inputs are scrambled right after accept
    task automatic issue_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                            output logic [7:0] lo, output logic [7:0] hi, output logic [3:0] fl,
                            output int lat, output bit ok);
        int w;
        w = 0; lat = 0; ok = 1'b0;
        lo = '0; hi = '0; fl = '0;
        while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
        if (!in_ready) return;
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        ok = out_valid; lo = result; hi = result_hi; fl = flags;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        total_cnt++;
        if ({in_ready, out_valid, result, result_hi, flags} !== {1'b1, 1'b0, 8'h00, 8'h00, 4'h0}) begin
            $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h hi=%h flags=%b, want 1 0 00 00 0000",
                     in_ready, out_valid, result, result_hi, flags);
        end else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [3:0] ops [12] = '{4'b0001, 4'b0010, 4'b0010, 4'b0011, 4'b0011, 4'b0100,
                                 4'b0100, 4'b0100, 4'b0000, 4'b1111, 4'b0001, 4'b0011};
        logic [7:0] as [12]  = '{8'd200, 8'd5, 8'h80, 8'd15, 8'd255, 8'd100,
                                 8'd5, 8'd0, 8'd1, 8'h7F, 8'h80, 8'd0};
        logic [7:0] bs [12]  = '{8'd100, 8'd7, 8'd1, 8'd17, 8'd255, 8'd7,
                                 8'd0, 8'd3, 8'd2, 8'd1, 8'h80, 8'd77};
        logic [7:0] lo, hi;
        logic [3:0] fl;
        int lat;
        bit ok;
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            e = model(ops[i], as[i], bs[i]);
            issue_op(ops[i], as[i], bs[i], lo, hi, fl, lat, ok);
            total_cnt++;
            if (!ok) $display("FAIL directed_timeout[%0d]: no out_valid, want lat=%0d", i, e.lat);
            else if ({lo, hi, fl} !== {e.lo, e.hi, e.fl})
                $display("FAIL directed_data[%0d]: op=%b a=%h b=%h got lo=%h hi=%h fl=%b want lo=%h hi=%h fl=%b",
                         i, ops[i], as[i], bs[i], lo, hi, fl, e.lo, e.hi, e.fl);
            else pass_cnt++;
            total_cnt++;
            if (lat !== e.lat) $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, e.lat);
            else pass_cnt++;
            consume();
        end
    endtask

    task automatic test_random_ops();
        logic [3:0] o;
        logic [7:0] x, y, lo, hi;
        logic [3:0] fl;
        int lat;
        bit ok;
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            o = (i % 4 == 0) ? 4'($urandom) : 4'($urandom_range(1, 4));
            x = 8'($urandom); y = 8'($urandom);
            if (i % 7 == 3) y = 8'h00;
            e = model(o, x, y);
            issue_op(o, x, y, lo, hi, fl, lat, ok);
            total_cnt++;
            if (!ok || {lo, hi, fl} !== {e.lo, e.hi, e.fl} || lat !== e.lat)
                $display("FAIL random[%0d]: op=%b a=%h b=%h got ok=%b lo=%h hi=%h fl=%b lat=%0d want lo=%h hi=%h fl=%b lat=%0d",
                         i, o, x, y, ok, lo, hi, fl, lat, e.lo, e.hi, e.fl, e.lat);
            else pass_cnt++;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            consume();
        end
    endtask

    task automatic test_hold();
        logic [7:0] lo, hi;
        logic [3:0] fl;
        int lat;
        bit ok;
        exp_t e;
        e = model(4'b0011, 8'd13, 8'd29);
        issue_op(4'b0011, 8'd13, 8'd29, lo, hi, fl, lat, ok);
        total_cnt++;
        if (!ok || {lo, hi, fl} !== {e.lo, e.hi, e.fl})
            $display("FAIL hold_first: ok=%b got %h %h %b want %h %h %b", ok, lo, hi, fl, e.lo, e.hi, e.fl);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; op = 4'b0001; a = 8'($urandom); b = 8'($urandom);
            @(posedge clk); #1;
            total_cnt++;
            if ({out_valid, in_ready, result, result_hi, flags} !== {1'b1, 1'b0, e.lo, e.hi, e.fl})
                $display("FAIL hold_stable[%0d]: got v=%b r=%b %h %h %b want v=1 r=0 %h %h %b",
                         i, out_valid, in_ready, result, result_hi, flags, e.lo, e.hi, e.fl);
            else pass_cnt++;
        end
        // in_valid still high across the DONE->IDLE edge must not be taken
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL hold_release: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        else pass_cnt++;
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        int n_out;
        n_out = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            op = $urandom_range(0, 1) ? 4'b0010 : 4'b0001;
            a = 8'($urandom); b = 8'($urandom);
            if (in_ready) q.push_back(model(op, a, b));
            @(posedge clk); #1;
            if (out_valid) begin
                n_out++;
                total_cnt++;
                if (q.size() == 0) $display("FAIL b2b_spurious[%0d]: out_valid with nothing pending", i);
                else begin
                    e = q.pop_front();
                    if ({result, result_hi, flags} !== {e.lo, e.hi, e.fl})
                        $display("FAIL b2b_data[%0d]: got %h %h %b want %h %h %b",
                                 i, result, result_hi, flags, e.lo, e.hi, e.fl);
                    else pass_cnt++;
                end
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total_cnt++;
        if (n_out !== 10) $display("FAIL b2b_throughput: got %0d results in 20 cycles want 10", n_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_busy();
        logic [7:0] lo, hi;
        logic [3:0] fl;
        int lat, seen;
        bit ok;
        exp_t e;
        op = 4'b0011; a = 8'd99; b = 8'd77; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid, in_ready, result, result_hi, flags} !== {1'b0, 1'b1, 8'h00, 8'h00, 4'h0})
            $display("FAIL reset_busy: got v=%b r=%b %h %h %b want 0 1 00 00 0000",
                     out_valid, in_ready, result, result_hi, flags);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL reset_stale: out_valid seen %0d cycles want 0", seen);
        else pass_cnt++;
        e = model(4'b0001, 8'd3, 8'd4);
        issue_op(4'b0001, 8'd3, 8'd4, lo, hi, fl, lat, ok);
        total_cnt++;
        if (!ok || {lo, hi, fl, lat} !== {e.lo, e.hi, e.fl, e.lat})
            $display("FAIL reset_recover: ok=%b got %h %h %b lat=%0d want %h %h %b lat=%0d",
                     ok, lo, hi, fl, lat, e.lo, e.hi, e.fl, e.lat);
        else pass_cnt++;
        consume();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_random_ops();
        test_reset_busy();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
